// File: rtl/packet_averager.sv
// Coherent pulse integrator: accumulates 2^K SoP/EoP-framed packets bin by bin
// in on-chip RAM and streams out the averaged last packet with the same framing.
// A two-stage read-modify-write pipeline gives a fixed 2-cycle strobe latency.
module packet_averager #(
   parameter int N_BINS   = 2500,
   parameter int MAX_LOG2 = 7,
   parameter int ACC_W    = 14 + MAX_LOG2
) (
   input  logic        ipClk,
   input  logic        ipnReset,
   input  logic [2:0]  ipLog2Count,
   input  logic        ipClearError,
   input  logic        ipSoP,
   input  logic        ipEoP,
   input  logic [13:0] ipData,
   input  logic        ipValid,
   output logic        opSoP,
   output logic        opEoP,
   output logic [13:0] opData,
   output logic        opValid,
   output logic        opError,
   output logic        opBusy
);

   // n must be able to hold N_BINS itself so a missing EoP is detectable
   localparam int NW  = $clog2(N_BINS + 1);
   localparam int RAW = (N_BINS > 1) ? $clog2(N_BINS) : 1;
   localparam logic [NW-1:0]       N_LAST = NW'(N_BINS - 1);
   localparam logic [NW-1:0]       N_END  = NW'(N_BINS);
   localparam logic [NW-1:0]       N_ONE  = NW'(1'b1);
   localparam logic [2:0]          MAXK   = 3'(MAX_LOG2);
   localparam logic [MAX_LOG2-1:0] P_ONES = '1;
   localparam logic [MAX_LOG2-1:0] P_ONE  = MAX_LOG2'(1'b1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,   // no set in progress
      ST_ACC  = 2'd1,   // inside a packet
      ST_WAIT = 2'd2    // between packets of a set, expecting the next SoP
   } state_t;

   // Index of the last packet of a set averaging 2^k packets
   function automatic logic [MAX_LOG2-1:0] last_pkt(input logic [2:0] k);
      return P_ONES >> (MAXK - k);
   endfunction

   // Sign-extend a 14-bit sample to accumulator width
   function automatic logic signed [ACC_W-1:0] sext(input logic [13:0] d);
      return {{(ACC_W-14){d[13]}}, d};
   endfunction

   state_t               state_q, state_d;
   logic [NW-1:0]        n_q, n_d;
   logic [MAX_LOG2-1:0]  p_q, p_d;
   logic [2:0]           k_q, k_d;
   logic [2:0]           k_new_s;

   logic                 proc_s;
   logic [RAW-1:0]       proc_addr_s;
   logic                 proc_first_s;
   logic                 proc_emit_s;
   logic                 err_set_s;

   logic                 s1_valid_q, s1_sop_q, s1_eop_q, s1_first_q, s1_emit_q;
   logic [13:0]          s1_data_q;
   logic [RAW-1:0]       s1_addr_q;
   logic [2:0]           s1_k_q;

   logic signed [ACC_W-1:0] mem [N_BINS];
   logic signed [ACC_W-1:0] rd_q;
   logic signed [ACC_W-1:0] sum_s;
   logic signed [ACC_W-1:0] shifted_s;

   logic                 out_valid_d, out_sop_d, out_eop_d, err_d, busy_d;
   logic [13:0]          out_data_d;
   logic                 out_valid_q, out_sop_q, out_eop_q, err_q, busy_q;
   logic [13:0]          out_data_q;

   // FSM state register
   always_ff @(posedge ipClk or negedge ipnReset) begin
      if (!ipnReset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: framing checks, counters and per-sample processing decision
   always_comb begin
      state_d      = state_q;
      n_d          = n_q;
      p_d          = p_q;
      k_d          = k_q;
      k_new_s      = (ipLog2Count > MAXK) ? MAXK : ipLog2Count;
      proc_s       = 1'b0;
      proc_addr_s  = '0;
      proc_first_s = (p_q == '0);
      proc_emit_s  = (p_q == last_pkt(k_q));
      err_set_s    = 1'b0;
      if (ipValid) begin
         case (state_q)
            ST_IDLE, ST_ACC: begin
               if (ipSoP) begin
                  // set start; a SoP inside a packet is an error that restarts the set
                  if (state_q == ST_ACC) begin
                     err_set_s = 1'b1;
                  end else begin
                     err_set_s = 1'b0;
                  end
                  k_d          = k_new_s;
                  p_d          = '0;
                  proc_first_s = 1'b1;
                  proc_emit_s  = (last_pkt(k_new_s) == '0);
                  if (ipEoP) begin
                     err_set_s = 1'b1;
                     n_d       = '0;
                     state_d   = ST_IDLE;
                  end else begin
                     proc_s  = 1'b1;
                     n_d     = N_ONE;
                     state_d = ST_ACC;
                  end
               end else if (state_q == ST_IDLE) begin
                  // stray sample outside a set is ignored
                  n_d = '0;
               end else if (n_q == N_END) begin
                  // long packet: extra sample beyond the last bin
                  err_set_s = 1'b1;
                  n_d       = '0;
                  p_d       = '0;
                  state_d   = ST_IDLE;
               end else if (ipEoP) begin
                  if (n_q == N_LAST) begin
                     proc_s      = 1'b1;
                     proc_addr_s = n_q[RAW-1:0];
                     n_d         = '0;
                     if (p_q == last_pkt(k_q)) begin
                        p_d     = '0;
                        state_d = ST_IDLE;
                     end else begin
                        p_d     = p_q + P_ONE;
                        state_d = ST_WAIT;
                     end
                  end else begin
                     // short packet
                     err_set_s = 1'b1;
                     n_d       = '0;
                     p_d       = '0;
                     state_d   = ST_IDLE;
                  end
               end else begin
                  proc_s      = 1'b1;
                  proc_addr_s = n_q[RAW-1:0];
                  n_d         = n_q + N_ONE;
               end
            end
            ST_WAIT: begin
               if (ipSoP && !ipEoP) begin
                  proc_s  = 1'b1;
                  n_d     = N_ONE;
                  state_d = ST_ACC;
               end else begin
                  // missing SoP, or a one-sample packet
                  err_set_s = 1'b1;
                  n_d       = '0;
                  p_d       = '0;
                  state_d   = ST_IDLE;
               end
            end
            default: begin
               n_d     = '0;
               p_d     = '0;
               state_d = ST_IDLE;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Set counters and latched K
   always_ff @(posedge ipClk or negedge ipnReset) begin
      if (!ipnReset) begin
         n_q <= '0;
         p_q <= '0;
         k_q <= '0;
      end else begin
         n_q <= n_d;
         p_q <= p_d;
         k_q <= k_d;
      end
   end

   // Pipeline stage 1: carries the accepted sample while the RAM read completes
   always_ff @(posedge ipClk or negedge ipnReset) begin
      if (!ipnReset) begin
         s1_valid_q <= 1'b0;
         s1_sop_q   <= 1'b0;
         s1_eop_q   <= 1'b0;
         s1_first_q <= 1'b0;
         s1_emit_q  <= 1'b0;
         s1_data_q  <= 14'd0;
         s1_addr_q  <= '0;
         s1_k_q     <= 3'd0;
      end else begin
         s1_valid_q <= proc_s;
         s1_sop_q   <= ipSoP;
         s1_eop_q   <= ipEoP;
         s1_first_q <= proc_first_s;
         s1_emit_q  <= proc_emit_s;
         s1_data_q  <= ipData;
         s1_addr_q  <= proc_addr_s;
         s1_k_q     <= k_d;
      end
   end

   // Accumulator RAM: synchronous read of bin n, write-back of bin n-1
   always_ff @(posedge ipClk) begin
      rd_q <= mem[proc_addr_s];
      if (s1_valid_q) begin
         mem[s1_addr_q] <= sum_s;
      end
   end

   // Output logic: accumulate, scale, and next values of the registered outputs
   always_comb begin
      if (s1_first_q) begin
         sum_s = sext(s1_data_q);
      end else begin
         sum_s = rd_q + sext(s1_data_q);
      end
      shifted_s   = sum_s >>> s1_k_q;
      out_valid_d = s1_valid_q & s1_emit_q;
      out_sop_d   = out_valid_d & s1_sop_q;
      out_eop_d   = out_valid_d & s1_eop_q;
      if (out_valid_d) begin
         out_data_d = shifted_s[13:0];
      end else begin
         out_data_d = out_data_q;
      end
      if (err_set_s) begin
         err_d = 1'b1;
      end else if (ipClearError) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end
      busy_d = (state_d != ST_IDLE) | s1_valid_q;
   end

   // Registered outputs
   always_ff @(posedge ipClk or negedge ipnReset) begin
      if (!ipnReset) begin
         out_valid_q <= 1'b0;
         out_sop_q   <= 1'b0;
         out_eop_q   <= 1'b0;
         out_data_q  <= 14'd0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_sop_q   <= out_sop_d;
         out_eop_q   <= out_eop_d;
         out_data_q  <= out_data_d;
         err_q       <= err_d;
         busy_q      <= busy_d;
      end
   end

   assign opValid = out_valid_q;
   assign opSoP   = out_sop_q;
   assign opEoP   = out_eop_q;
   assign opData  = out_data_q;
   assign opError = err_q;
   assign opBusy  = busy_q;

endmodule

// File: tb/tb_packet_averager.sv
// Scoreboard bench for packet_averager: the driver computes expected averaged
// samples with plain integer floor division and queues them; a monitor pops and
// compares whenever opValid is seen, including the expected output cycle.
module tb_packet_averager;

   localparam int TB_N       = 24;
   localparam int TB_MAXLOG2 = 3;

   logic        clk = 1'b0;
   logic        ipnReset, ipClearError, ipSoP, ipEoP, ipValid;
   logic [2:0]  ipLog2Count;
   logic [13:0] ipData;
   logic        opSoP, opEoP, opValid, opError, opBusy;
   logic [13:0] opData;

   typedef struct {
      logic [13:0] d;
      logic        sop;
      logic        eop;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cval[8];

   packet_averager #(.N_BINS(TB_N), .MAX_LOG2(TB_MAXLOG2), .ACC_W(14 + TB_MAXLOG2)) dut (
      .ipClk(clk), .ipnReset(ipnReset), .ipLog2Count(ipLog2Count), .ipClearError(ipClearError),
      .ipSoP(ipSoP), .ipEoP(ipEoP), .ipData(ipData), .ipValid(ipValid),
      .opSoP(opSoP), .opEoP(opEoP), .opData(opData), .opValid(opValid),
      .opError(opError), .opBusy(opBusy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // monitor: compare every presented output sample with the scoreboard head
   always @(negedge clk) begin
      exp_t e;
      if (ipnReset && opValid) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_output: got data=%0d sop=%0b eop=%0b at cyc=%0d, want no output",
                     $signed(opData), opSoP, opEoP, cyc);
         end else begin
            e = sb.pop_front();
            if (opData !== e.d || opSoP !== e.sop || opEoP !== e.eop || cyc != e.cyc) begin
               n_bad++;
               $display("FAIL out_sample: got data=%0d sop=%0b eop=%0b cyc=%0d, want data=%0d sop=%0b eop=%0b cyc=%0d",
                        $signed(opData), opSoP, opEoP, cyc, $signed(e.d), e.sop, e.eop, e.cyc);
            end
         end
      end else if (ipnReset && (opSoP || opEoP)) begin
         n_cmp++;
         n_bad++;
         $display("FAIL stray_strobe: got sop=%0b eop=%0b without valid, want none", opSoP, opEoP);
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   function automatic int floor_div(input int s, input int k);
      int d;
      int q;
      d = 1 << k;
      q = s / d;
      if ((s % d) != 0 && s < 0) q = q - 1;
      return q;
   endfunction

   function automatic int rnd_sample();
      if ($urandom_range(0, 3) == 0) return ($urandom_range(0, 1) == 1) ? 8191 : -8192;
      return int'($urandom_range(0, 16383)) - 8192;
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         ipValid = 1'b0;
         ipSoP   = 1'b0;
         ipEoP   = 1'b0;
      end
   endtask

   // one valid sample, optionally preceded by random gap cycles; queue expectation if emitted
   task automatic drive(input bit sop, input bit eop, input int d, input logic [2:0] lg,
                        input bit push, input int ed, input bit gaps);
      exp_t e;
      if (gaps) begin
         repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            ipValid = 1'b0;
            ipSoP   = 1'($urandom);
            ipEoP   = 1'($urandom);
            ipData  = 14'($urandom);
         end
      end
      @(negedge clk);
      ipValid     = 1'b1;
      ipSoP       = sop;
      ipEoP       = eop;
      ipData      = 14'(d);
      ipLog2Count = lg;
      if (push) begin
         e.d   = 14'(ed);
         e.sop = sop;
         e.eop = eop;
         e.cyc = cyc + 2;
         sb.push_back(e);
      end
   endtask

   // a clean set; mode 0 random, 1 ramp, 2 per-packet constant cval[p]
   task automatic run_set(input logic [2:0] lg, input int mode, input bit gaps);
      int k;
      int np;
      int d;
      int acc[TB_N];
      k  = (int'(lg) > TB_MAXLOG2) ? TB_MAXLOG2 : int'(lg);
      np = 1 << k;
      for (int p = 0; p < np; p++) begin
         for (int n = 0; n < TB_N; n++) begin
            case (mode)
               0: d = rnd_sample();
               1: d = n - TB_N / 2;
               2: d = cval[p];
               default: d = 0;
            endcase
            acc[n] = (p == 0) ? d : acc[n] + d;
            drive(n == 0, n == TB_N - 1, d, (p == 0 && n == 0) ? lg : 3'($urandom_range(0, 7)),
                  p == np - 1, floor_div(acc[n], k), gaps);
         end
      end
      @(negedge clk);
      ipValid = 1'b0;
      @(negedge clk);
      check("busy_at_last_output", opBusy, 1);
      @(negedge clk);
      check("busy_after_last_output", opBusy, 0);
   endtask

   task automatic clear_err();
      @(negedge clk);
      ipValid      = 1'b0;
      ipClearError = 1'b1;
      @(negedge clk);
      ipClearError = 1'b0;
      check("err_cleared", opError, 0);
   endtask

   initial begin
      int acc2[TB_N];
      int d;
      ipnReset = 1'b0; ipClearError = 1'b0; ipSoP = 1'b0; ipEoP = 1'b0;
      ipValid = 1'b0; ipData = 14'd0; ipLog2Count = 3'd0;
      repeat (3) @(negedge clk);
      check("rst_valid", opValid, 0);
      check("rst_sop", opSoP, 0);
      check("rst_eop", opEoP, 0);
      check("rst_data", opData, 0);
      check("rst_error", opError, 0);
      check("rst_busy", opBusy, 0);
      @(negedge clk);
      ipnReset = 1'b1;

      // stray samples in Idle are ignored
      repeat (3) begin
         @(negedge clk);
         ipValid = 1'b1; ipSoP = 1'b0; ipEoP = 1'($urandom); ipData = 14'($urandom);
      end
      idle(3);
      check("idle_stray_err", opError, 0);
      check("idle_stray_busy", opBusy, 0);

      // K=0 ramp passes straight through
      run_set(3'd0, 1, 0);
      check("k0_err", opError, 0);
      // K=2 constants 100..103 -> 101
      cval[0] = 100; cval[1] = 101; cval[2] = 102; cval[3] = 103;
      run_set(3'd2, 2, 1);
      // K=3 full scale negative, then positive with K clamped from 7
      for (int i = 0; i < 8; i++) cval[i] = -8191;
      run_set(3'd3, 2, 1);
      for (int i = 0; i < 8; i++) cval[i] = 8191;
      run_set(3'd7, 2, 0);
      // K=1 floor rounding
      cval[0] = -3; cval[1] = 0;
      run_set(3'd1, 2, 0);
      cval[0] = 3;
      run_set(3'd1, 2, 1);
      check("clean_sets_err", opError, 0);

      // short second packet of a K=2 set
      for (int n = 0; n < TB_N; n++) drive(n == 0, n == TB_N - 1, rnd_sample(), 3'd2, 0, 0, 0);
      for (int n = 0; n <= 10; n++) drive(n == 0, n == 10, rnd_sample(), 3'd2, 0, 0, 0);
      idle(1);
      check("short_pkt_err", opError, 1);
      run_set(3'd2, 0, 1);
      check("err_sticky", opError, 1);
      clear_err();

      // SoP in mid-packet restarts the set
      for (int n = 0; n < 7; n++) drive(n == 0, 1'b0, rnd_sample(), 3'd1, 0, 0, 0);
      run_set(3'd1, 0, 0);
      check("sop_restart_err", opError, 1);
      clear_err();

      // long packet with K=0: first N bins emitted, extra sample aborts
      for (int n = 0; n <= TB_N; n++) begin
         d = rnd_sample();
         drive(n == 0, 1'b0, d, 3'd0, n < TB_N, d, 0);
      end
      idle(1);
      check("long_pkt_err", opError, 1);
      check("long_pkt_busy", opBusy, 1);
      idle(2);
      clear_err();

      // short last packet with K=0: emitted samples stand, no EoP
      for (int n = 0; n <= 10; n++) begin
         d = rnd_sample();
         drive(n == 0, n == 10, d, 3'd0, n < 10, d, 1);
      end
      idle(1);
      check("abort_last_err", opError, 1);
      idle(2);
      check("abort_idle_busy", opBusy, 0);
      clear_err();

      // missing SoP between packets, coinciding with a clear pulse
      for (int n = 0; n < TB_N; n++) drive(n == 0, n == TB_N - 1, rnd_sample(), 3'd1, 0, 0, 0);
      @(negedge clk);
      ipValid = 1'b1; ipSoP = 1'b0; ipEoP = 1'b0; ipClearError = 1'b1;
      @(negedge clk);
      ipValid = 1'b0; ipClearError = 1'b0;
      check("err_beats_clear", opError, 1);
      clear_err();

      // every-cycle K=1 set, then a reset during the last packet
      run_set(3'd1, 0, 0);
      for (int n = 0; n < TB_N; n++) begin
         acc2[n] = rnd_sample();
         drive(n == 0, n == TB_N - 1, acc2[n], 3'd1, 0, 0, 0);
      end
      for (int n = 0; n <= 10; n++) begin
         d = rnd_sample();
         drive(n == 0, 1'b0, d, 3'd1, 1, floor_div(acc2[n] + d, 1), 0);
      end
      @(negedge clk);
      #2;
      ipnReset = 1'b0;
      ipValid  = 1'b0;
      #1;
      check("mid_rst_valid", opValid, 0);
      check("mid_rst_data", opData, 0);
      check("mid_rst_busy", opBusy, 0);
      check("mid_rst_err", opError, 0);
      sb.delete();
      idle(2);
      @(negedge clk);
      ipnReset = 1'b1;
      run_set(3'd1, 0, 1);

      // random sets
      repeat (5) run_set(3'($urandom_range(0, 7)), 0, 1'($urandom));

      idle(10);
      check("scoreboard_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/packet_averager.md
Name: packet_averager

Overview:
- Coherent pulse integrator directly downstream of the receiver packet stage.
- Consumes the receiver's packet stream: SoP/EoP-framed, 14-bit two's-complement samples, one packet per trigger.
- Accumulates 2^K consecutive packets bin-by-bin in on-chip RAM, then emits one averaged packet with the same framing.
- Feeds the debug streamer and the downstream processing chain.

Parameters:
- N_BINS, 2500, samples per packet; must be ≥ 2.
- MAX_LOG2, 7, largest supported K (up to 128 packets averaged).
- ACC_W, 21, accumulator width = 14 + MAX_LOG2.

Ports:
- ipClk  in  1  DSP clock; all logic on its rising edge.
- ipnReset  in  1  asynchronous, active-low reset.
- ipLog2Count  in  3  K; averages 2^K packets. Sampled only at the start of a set.
- ipClearError  in  1  single-cycle pulse; clears opError.
- ipSoP  in  1  start of packet; qualified by ipValid.
- ipEoP  in  1  end of packet; qualified by ipValid.
- ipData  in  14  signed sample.
- ipValid  in  1  sample strobe; may assert on consecutive cycles.
- opSoP  out  1  averaged-packet start of packet.
- opEoP  out  1  averaged-packet end of packet.
- opData  out  14  averaged signed sample.
- opValid  out  1  output sample strobe.
- opError  out  1  sticky framing-error flag.
- opBusy  out  1  high while a set is in progress.

Behaviour:
- Reset (ipnReset low, asynchronous):
  - opValid, opSoP, opEoP, opError, opBusy = 0; opData = 0.
  - State = Idle; packet counter p = 0; bin counter n = 0.
  - Any partial set is discarded. RAM contents are don't-care.
- States:
  - Idle:
    - Valid without SoP is ignored.
    - Valid with SoP: latch K = min(ipLog2Count, MAX_LOG2); set p = 0 and n = 0; process the sample; go to Accumulate; opBusy = 1.
  - Accumulate:
    - Each valid sample is processed at bin n, then n increments.
    - On a valid EoP with n == N_BINS-1:
      - If p == 2^K-1: go to Idle; opBusy = 0 one cycle after the final output.
      - Otherwise: p increments and the block waits for the next SoP, staying in Accumulate with n = 0.
- Per-sample arithmetic (read-modify-write pipeline):
  - Cycle 0: RAM read at address n.
  - Cycle 1: sum = (p == 0 ? 0 : RAM[n]) + sign_extend(ipData); write sum to RAM[n].
  - Back-to-back valids are legal. Read address n and write address n-1 never collide because N_BINS ≥ 2, so no forwarding is needed.
- Output, last packet of a set only (p == 2^K-1):
  - Intermediate packets produce no output.
  - opData = sum >>> K (arithmetic shift, truncation toward −∞), then the low 14 bits.
  - Cannot overflow, since |sum| ≤ 2^K·2^13.
  - opValid/opSoP/opEoP follow the corresponding input strobes with a fixed latency of 2 cycles.
  - Strobes are single-cycle.
  - With K = 0 the output is the input delayed by 2 cycles.
- Framing errors: each sets opError and sends the block to Idle, abandoning the set; no partial output packet is completed.
  - SoP with n ≠ 0 mid-packet: flag the error, then treat this sample as a fresh set start (p = 0, re-latch K).
  - EoP with n ≠ N_BINS-1 (short packet): flag the error, go to Idle.
  - n reaches N_BINS without EoP (long packet): flag the error on the extra sample, go to Idle.
  - Valid without SoP while waiting for the next SoP between packets: flag the error, go to Idle.
- Output side effect of an abort: if the abort occurs on the last packet, output samples already emitted stand. opEoP is not generated.
- Error flag timing:
  - opError is cleared by ipClearError.
  - A new error in the same cycle as ipClearError wins (flag stays 1).
- ipLog2Count changes during a set have no effect until the next set start.

Test Plan:
- K=0, one packet with ramp data −1250..1249 → output identical, 2-cycle latency; opSoP on the first sample and opEoP on the last; opError = 0.
- K=2, four packets with constant samples 100, 101, 102, 103 → only after the fourth packet: every opData = 101 (406>>>2); opBusy falls after the final EoP.
- K=3, all samples −8191 for 8 packets → opData = −8191. Then 8 packets of +8191 → opData = 8191 (full-scale sums, no wrap).
- K=1, samples −3 then 0 → sum −3, opData = −2 (floor); samples +3 then 0 → opData = +1.
- K=2, second packet ends with EoP at n=1000 → opError = 1, no output, Idle. Next clean 4-packet set → correct averages, opError still 1 until ipClearError pulses, then 0.
- ipValid on every cycle for a whole set with K=1, plus a mid-set ipnReset assertion in a second run → first run correct with no dropped bins. Second run: all outputs 0 immediately; a subsequent set averages correctly with no residue from the aborted one.
